// File: rtl/image_pkg.sv
// Shared image-store definitions: geometry defaults, display colours and
// the writer state encoding.
package image_pkg;

    localparam int DEF_REDUCED_PIXELS = 19;
    localparam int DEF_REDUCED_LINES  = 10;

    localparam logic [7:0] FG_COLOUR = 8'hE0;
    localparam logic [7:0] BG_COLOUR = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } writer_state_t;

    function automatic int bytes_for(input int pixels);
        return (pixels + 7) / 8;
    endfunction

    function automatic int addr_bits(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/image_line_packer.sv
// Packs incoming pixel bytes into one line word; bits beyond the line
// width in the final byte are dropped.
module image_line_packer
    import image_pkg::*;
#(
    parameter int PIXELS = DEF_REDUCED_PIXELS,
    parameter int BYTES  = bytes_for(DEF_REDUCED_PIXELS)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CE,
    input  logic              frame_start,
    input  logic              load,
    input  logic              clear,
    input  logic [7:0]        data,
    output logic [PIXELS-1:0] line_word,
    output logic              last_byte
);

    localparam int IDX_W = (BYTES < 2) ? 1 : $clog2(BYTES);

    logic [PIXELS-1:0] pack_q;
    logic [IDX_W-1:0]  idx_q;

    // Line word as it would look with the current byte merged in
    always_comb begin
        line_word = pack_q;
        for (int i = 0; i < PIXELS; i++) begin
            if (idx_q == IDX_W'(i / 8))
                line_word[i] = data[i % 8];
        end
    end

    assign last_byte = (idx_q == IDX_W'(BYTES - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pack_q <= '0;
            idx_q  <= '0;
        end else if (CE) begin
            if (frame_start || clear) begin
                pack_q <= '0;
                idx_q  <= '0;
            end else if (load) begin
                pack_q <= line_word;
                idx_q  <= last_byte ? '0 : idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_writer.sv
// Byte-stream to line-memory loader for the 1bpp image store.
// Optional trailing XOR checksum byte: define IMAGE_WRITER_CHECKSUM_EN.
module image_writer
    import image_pkg::*;
#(
    parameter  int REDUCED_PIXELS = DEF_REDUCED_PIXELS,
    parameter  int REDUCED_LINES  = DEF_REDUCED_LINES,
    localparam int BYTES_PER_LINE = bytes_for(REDUCED_PIXELS),
    localparam int ADDR_W         = addr_bits(REDUCED_LINES)
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      CE,
    input  logic                      START,
    input  logic [7:0]                DATA_IN,
    input  logic                      VALID_IN,
    output logic                      READY_OUT,
    output logic                      WR_EN,
    output logic [ADDR_W-1:0]         WR_ADDR,
    output logic [REDUCED_PIXELS-1:0] WR_DATA,
    output logic                      BUSY,
    output logic                      FRAME_DONE,
    output logic                      FRAME_ERR
);

    writer_state_t             state_q;
    logic [ADDR_W-1:0]         line_q;
    logic [ADDR_W-1:0]         wr_addr_q;
    logic [REDUCED_PIXELS-1:0] wr_data_q;
    logic [REDUCED_PIXELS-1:0] line_word;
    logic                      last_byte;
    logic                      xfer;
    logic                      byte_xfer;
    logic                      start_ok;
    logic                      last_line;

`ifdef IMAGE_WRITER_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       err_q;
`endif

    assign READY_OUT = CE && (state_q == ST_COLLECT
                           || state_q == ST_CHECK);
    assign xfer      = VALID_IN && READY_OUT;
    assign byte_xfer = xfer && (state_q == ST_COLLECT);
    assign start_ok  = CE && START && (state_q == ST_IDLE);
    assign last_line = (line_q == ADDR_W'(REDUCED_LINES - 1));

    assign WR_EN      = CE && (state_q == ST_WRITE);
    assign FRAME_DONE = CE && (state_q == ST_DONE);
    assign BUSY       = (state_q != ST_IDLE);
    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;

`ifdef IMAGE_WRITER_CHECKSUM_EN
    assign FRAME_ERR = err_q;
`else
    assign FRAME_ERR = 1'b0;
`endif

    image_line_packer #(
        .PIXELS(REDUCED_PIXELS),
        .BYTES (BYTES_PER_LINE)
    ) u_packer (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .CE         (CE),
        .frame_start(start_ok),
        .load       (byte_xfer),
        .clear      (state_q == ST_WRITE),
        .data       (DATA_IN),
        .line_word  (line_word),
        .last_byte  (last_byte)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMAGE_WRITER_CHECKSUM_EN
            xor_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else if (CE) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q <= ST_COLLECT;
                        line_q  <= '0;
`ifdef IMAGE_WRITER_CHECKSUM_EN
                        xor_q   <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (byte_xfer) begin
`ifdef IMAGE_WRITER_CHECKSUM_EN
                        xor_q <= xor_q ^ DATA_IN;
`endif
                        // Capture the finished line so it stays on the bus
                        if (last_byte) begin
                            wr_data_q <= line_word;
                            wr_addr_q <= line_q;
                            state_q   <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (last_line) begin
`ifdef IMAGE_WRITER_CHECKSUM_EN
                        state_q <= ST_CHECK;
`else
                        state_q <= ST_DONE;
`endif
                    end else begin
                        line_q  <= line_q + 1'b1;
                        state_q <= ST_COLLECT;
                    end
                end
`ifdef IMAGE_WRITER_CHECKSUM_EN
                ST_CHECK: begin
                    if (xfer) begin
                        err_q   <= (DATA_IN != xor_q);
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_writer.sv
// Scoreboarded random-frame bench for image_writer.
module tb_image_writer;
    import image_pkg::*;

    localparam int PIX   = 19;
    localparam int LINES = 10;
    localparam int BPL   = (PIX + 7) / 8;
    localparam int AW    = 4;
    localparam int NB    = LINES * BPL;

    logic           CLK;
    logic           RESET_N;
    logic           CE;
    logic           START;
    logic [7:0]     DATA_IN;
    logic           VALID_IN;
    logic           READY_OUT;
    logic           WR_EN;
    logic [AW-1:0]  WR_ADDR;
    logic [PIX-1:0] WR_DATA;
    logic           BUSY;
    logic           FRAME_DONE;
    logic           FRAME_ERR;

    image_writer #(
        .REDUCED_PIXELS(PIX),
        .REDUCED_LINES (LINES)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .CE        (CE),
        .START     (START),
        .DATA_IN   (DATA_IN),
        .VALID_IN  (VALID_IN),
        .READY_OUT (READY_OUT),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE),
        .FRAME_ERR (FRAME_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [PIX-1:0] data;
    } wr_t;

    wr_t wr_q[$];
    bit  done_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel i of a line is bit (i mod 8) of byte (i div 8)
    function automatic logic [PIX-1:0] ref_line(input logic [7:0] b[BPL]);
        logic [PIX-1:0] w;
        for (int i = 0; i < PIX; i++) w[i] = b[i / 8][i % 8];
        return w;
    endfunction

    // Monitor: compare every observed write and frame end with the queues
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (WR_EN) begin
                check("write_expected", 64'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", WR_ADDR, e.addr);
                    check("wr_data", WR_DATA, e.data);
                end
            end
            if (FRAME_DONE) begin
                check("done_expected", 64'(done_q.size() > 0), 1);
                if (done_q.size() > 0)
                    check("frame_err", FRAME_ERR, done_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit took;
        n = 0;
        took = 0;
        DATA_IN = b;
        VALID_IN = 1'b1;
        while (!took && n < 50) begin
            #1;
            took = READY_OUT;
            @(posedge CLK);
            if (!took) begin
                @(negedge CLK);
                n++;
            end
        end
        check("handshake", took, 1);
        @(negedge CLK);
        VALID_IN = 1'b0;
    endtask

    task automatic pause_ce();
        CE = 1'b0;
        DATA_IN = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            START = (i == 2);
            VALID_IN = 1'b1;
            #1;
            check("ready_ce0", READY_OUT, 0);
            check("wren_ce0", WR_EN, 0);
            @(negedge CLK);
        end
        CE = 1'b1;
        VALID_IN = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_restart", BUSY, 1);
    endtask

    task automatic do_reset();
        #2;
        RESET_N = 1'b0;
        #1;
        check("reset_async_outputs",
              {WR_EN, WR_ADDR, WR_DATA, BUSY, READY_OUT, FRAME_DONE, FRAME_ERR},
              0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        check("no_partial_write", wr_q.size(), 0);
        @(negedge CLK);
    endtask

    task automatic run_frame(input logic [7:0] bytes[NB], input bit gap,
                             input bit disturb, input int abort_at,
                             input bit bad_sum, input bit directed);
        logic [7:0] x;
        logic [7:0] lb[BPL];
        int n;
        x = 8'h00;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        for (int l = 0; l < LINES; l++) begin
            for (int k = 0; k < BPL; k++) begin
                int idx;
                idx = l * BPL + k;
                if (idx == abort_at) begin
                    do_reset();
                    return;
                end
                if (disturb && idx == 7) pause_ce();
                lb[k] = bytes[idx];
                x = x ^ bytes[idx];
                if (k == BPL - 1)
                    wr_q.push_back('{addr: AW'(l), data: ref_line(lb)});
                send_byte(bytes[idx]);
                if (k == BPL - 1) begin
                    check("wr_latency", WR_EN, 1);
                    if (directed && l < 2)
                        check("directed_word", WR_DATA, 19'h73CA5);
                end
                if (gap) @(negedge CLK);
            end
        end
`ifdef IMAGE_WRITER_CHECKSUM_EN
        done_q.push_back(bad_sum);
        send_byte(bad_sum ? (x ^ 8'h5A) : x);
`else
        done_q.push_back(1'b0);
`endif
        n = 0;
        while (!FRAME_DONE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen", FRAME_DONE, 1);
        @(negedge CLK);
        check("busy_falls", BUSY, 0);
        check("done_single", FRAME_DONE, 0);
        check("addr_hold", WR_ADDR, LINES - 1);
`ifdef IMAGE_WRITER_CHECKSUM_EN
        check("err_held", FRAME_ERR, bad_sum);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] fa[NB];
    logic [7:0] fb[NB];

    initial begin
        RESET_N = 1'b0;
        CE = 1'b1;
        START = 1'b0;
        VALID_IN = 1'b0;
        DATA_IN = 8'h00;
        #2;
        check("reset_outputs",
              {WR_EN, WR_ADDR, WR_DATA, BUSY, READY_OUT, FRAME_DONE, FRAME_ERR},
              0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("idle_not_ready", READY_OUT, 0);

        for (int i = 0; i < NB; i++) fa[i] = 8'($urandom);
        fa[0] = 8'hA5; fa[1] = 8'h3C; fa[2] = 8'h07;
        fa[3] = 8'hA5; fa[4] = 8'h3C; fa[5] = 8'hFF;

        run_frame(fa, 1, 0, -1, 0, 1);
        run_frame(fa, 0, 1, -1, 0, 1);

        for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
        run_frame(fb, 0, 0, 14, 0, 0);

        for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
        run_frame(fb, 0, 0, -1, 1, 0);

        for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
        run_frame(fb, 1'($urandom_range(0, 1)), 0, -1, 0, 0);

        repeat (3) @(negedge CLK);
        check("wr_queue_drained", wr_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
